intreg_cycle_ctrl: RTL

//  Zorro III slave-cycle sequencer for the interrupt register bank (INTREG/INTVEC/INTMASK at 0x900000-08).

---
 rtl/intreg_cycle_ctrl_pkg.sv | 37 +++
 rtl/intreg_cycle_ctrl_irq.sv | 41 ++++
 rtl/intreg_cycle_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/intreg_cycle_ctrl_pkg.sv
// Shared definitions for the Zorro III interrupt register bank sequencer:
// register addresses, FSM state and register-select encodings, reset values.
package intreg_cycle_ctrl_pkg;

  localparam logic [27:0] INTREG_ADDR  = 28'h0900000;
  localparam logic [27:0] INTVEC_ADDR  = 28'h0900004;
  localparam logic [27:0] INTMASK_ADDR = 28'h0900008;
  localparam logic [7:0]  INTVEC_RESET = 8'h18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_HOLD = 2'b11
  } cyc_state_t;

  typedef enum logic [1:0] {
    SEL_INTREG  = 2'b00,
    SEL_INTVEC  = 2'b01,
    SEL_INTMASK = 2'b10,
    SEL_NONE    = 2'b11
  } reg_sel_t;

  // Address bit 0 is ignored: registers match on ADDR[27:1].
  function automatic reg_sel_t decode_addr(input logic [27:0] addr);
    reg_sel_t sel;
    sel = SEL_NONE;
    if ((addr >> 1) == (INTREG_ADDR >> 1))
      sel = SEL_INTREG;
    else if ((addr >> 1) == (INTVEC_ADDR >> 1))
      sel = SEL_INTVEC;
    else if ((addr >> 1) == (INTMASK_ADDR >> 1))
      sel = SEL_INTMASK;
    return sel;
  endfunction

endpackage

// File: rtl/intreg_cycle_ctrl_irq.sv
// NCR 53C710 interrupt path: rising-edge detect, sticky pending bit,
// post-clear holdoff counter and the registered active-low host INT_n.
module intreg_cycle_ctrl_irq #(
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic NCR_INT,
  input  logic clear,
  input  logic mask_en,
  output logic pending,
  output logic INT_n
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic          ncr_prev;
  logic [HW-1:0] holdoff;

  // A new edge beats a simultaneous clear so no request is ever lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ncr_prev <= 1'b0;
      pending  <= 1'b0;
      holdoff  <= '0;
      INT_n    <= 1'b1;
    end else begin
      ncr_prev <= NCR_INT;
      if (NCR_INT && !ncr_prev)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
      if (clear)
        holdoff <= HW'(HOLDOFF_CYCLES);
      else if (holdoff != '0)
        holdoff <= holdoff - HW'(1);
      INT_n <= !(pending && mask_en && (holdoff == '0));
    end
  end

endmodule

// File: rtl/intreg_cycle_ctrl.sv
// Zorro III slave-cycle sequencer for INTREG/INTVEC/INTMASK: decode, wait
// states, commit, DTACK hold until FCS_n release or timeout.
module intreg_cycle_ctrl
  import intreg_cycle_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES    = 1,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [27:0] ADDR,
  input  logic        READ,
  input  logic        FCS_n,
  input  logic        slave_cycle,
  input  logic        configured,
  input  logic [7:0]  DIN,
  input  logic        NCR_INT,
  output logic        reg_dtack,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        INT_n,
  output logic        cyc_err
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  cyc_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [TW-1:0] tcnt, tcnt_next;
  reg_sel_t      sel_q, sel_next, addr_sel;
  logic          read_q, read_next;
  logic          hit, timed_out;
  logic          do_read, do_write, do_release, irq_clear;
  logic [7:0]    intvec, intmask, read_data;
  logic          pending;

  assign addr_sel  = decode_addr(ADDR);
  assign hit       = slave_cycle && configured && (addr_sel != SEL_NONE);
  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      tcnt   <= '0;
      sel_q  <= SEL_NONE;
      read_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      tcnt   <= tcnt_next;
      sel_q  <= sel_next;
      read_q <= read_next;
    end
  end

  // Releasing FCS_n while waiting aborts the cycle before anything commits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tcnt_next  = tcnt;
    sel_next   = sel_q;
    read_next  = read_q;
    case (state)
      ST_IDLE:
        if (!FCS_n && hit) begin
          state_next = ST_WAIT;
          cnt_next   = CW'(WAIT_CYCLES);
          sel_next   = addr_sel;
          read_next  = READ;
        end
      ST_WAIT:
        if (FCS_n)
          state_next = ST_IDLE;
        else if (cnt == '0)
          state_next = ST_ACK;
        else
          cnt_next = cnt - CW'(1);
      ST_ACK: begin
        state_next = ST_HOLD;
        tcnt_next  = '0;
      end
      ST_HOLD:
        if (FCS_n || timed_out)
          state_next = ST_IDLE;
        else
          tcnt_next = tcnt + TW'(1);
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    do_read    = (state == ST_ACK) && read_q;
    do_write   = (state == ST_ACK) && !read_q;
    do_release = (state == ST_HOLD) && (FCS_n || timed_out);
    irq_clear  = do_read && (sel_q == SEL_INTREG);
    case (sel_q)
      SEL_INTREG:  read_data = {6'b0, cyc_err, pending};
      SEL_INTVEC:  read_data = intvec;
      SEL_INTMASK: read_data = intmask;
      default:     read_data = 8'hFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_dtack <= 1'b0;
      DOUT      <= 8'hFF;
      DOE       <= 1'b0;
      cyc_err   <= 1'b0;
      intvec    <= INTVEC_RESET;
      intmask   <= 8'h00;
    end else begin
      if (state == ST_ACK)
        reg_dtack <= 1'b1;
      if (do_read) begin
        DOUT <= read_data;
        DOE  <= 1'b1;
      end
      if (do_write) begin
        if (sel_q == SEL_INTVEC)
          intvec <= DIN;
        else if (sel_q == SEL_INTMASK)
          intmask <= DIN;
      end
      if (do_release) begin
        reg_dtack <= 1'b0;
        DOE       <= 1'b0;
        DOUT      <= 8'hFF;
      end
      if (do_release && !FCS_n)
        cyc_err <= 1'b1;
      else if (irq_clear)
        cyc_err <= 1'b0;
    end
  end

  intreg_cycle_ctrl_irq #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_irq (
    .CLK    (CLK),
    .RESET  (RESET),
    .NCR_INT(NCR_INT),
    .clear  (irq_clear),
    .mask_en(intmask[0]),
    .pending(pending),
    .INT_n  (INT_n)
  );

endmodule
